// File: rtl/inst_loader_if.sv
// Byte-stream and memory write-port bundle for inst_loader.
// master: the loader (drives the write port); slave: UART side / memory side.
interface inst_loader_if #(
  parameter int NB_DATA   = 32,
  parameter int NB_BYTE   = 8,
  parameter int ADDRWIDTH = 7
);
  logic                 start_i;
  logic [NB_BYTE-1:0]   rx_data_i;
  logic                 rx_done_i;
  logic [NB_DATA-1:0]   inst_load_o;
  logic [ADDRWIDTH-1:0] wr_addr_o;
  logic                 en_write_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 overflow_o;
  logic                 timeout_o;
  logic [ADDRWIDTH:0]   inst_count_o;

  modport master (
    input  start_i, rx_data_i, rx_done_i,
    output inst_load_o, wr_addr_o, en_write_o, busy_o, done_o,
           overflow_o, timeout_o, inst_count_o
  );

  modport slave (
    output start_i, rx_data_i, rx_done_i,
    input  inst_load_o, wr_addr_o, en_write_o, busy_o, done_o,
           overflow_o, timeout_o, inst_count_o
  );
endinterface

// File: rtl/inst_loader.sv
// Packs UART bytes big-endian into instruction words and writes them to sequential addresses.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module inst_loader #(
  parameter int                 NB_DATA        = 32,
  parameter int                 NB_BYTE        = 8,
  parameter int                 ADDRWIDTH      = 7,
  parameter int                 MEM_DEPTH      = 128,
  parameter logic [NB_DATA-1:0] HALT_WORD      = 32'hFFFF_FFFF,
  parameter int                 TIMEOUT_CYCLES = 100000
) (
  input  logic          clock_i,
  input  logic          reset_i,
  inst_loader_if.master bus
);

  localparam int CW = ADDRWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [NB_DATA-1:0]   shift_r;
  logic [1:0]           byte_idx_r;
  logic [CW-1:0]        count_r;
  logic [NB_DATA-1:0]   inst_load_r;
  logic [ADDRWIDTH-1:0] wr_addr_r;
  logic                 en_write_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 overflow_r;
  logic                 timeout_r;
  logic                 tmo_expire_s;
  logic                 is_halt_s;
  logic                 last_addr_s;

  assign is_halt_s   = (shift_r == HALT_WORD);
  assign last_addr_s = (count_r == CW'(MEM_DEPTH - 1));

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  // Inter-byte silence counter, armed only once a word has been started
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      tmo_cnt_r <= '0;
    end else if ((state_r != ASSEMBLE) || bus.rx_done_i || (byte_idx_r == 2'd0)) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  assign tmo_expire_s = (state_r == ASSEMBLE) && (byte_idx_r != 2'd0) && !bus.rx_done_i &&
                        (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_s;

  assign tmo_expire_s = 1'b0;
  assign unused_tmo_s = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state selection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start_i) state_next_s = ASSEMBLE;
        else             state_next_s = IDLE;
      end
      ASSEMBLE: begin
        if (bus.rx_done_i && (byte_idx_r == 2'd3)) state_next_s = WRITE;
        else if (tmo_expire_s)                     state_next_s = DONE;
        else                                       state_next_s = ASSEMBLE;
      end
      WRITE: begin
        if (is_halt_s)        state_next_s = DONE;
        else if (last_addr_s) state_next_s = DONE;
        else                  state_next_s = ASSEMBLE;
      end
      DONE: begin
        if (bus.start_i) state_next_s = ASSEMBLE;
        else             state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, byte packing, write port and status registers
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      byte_idx_r  <= 2'd0;
      count_r     <= '0;
      inst_load_r <= '0;
      wr_addr_r   <= '0;
      en_write_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      busy_r     <= (state_next_s == ASSEMBLE) || (state_next_s == WRITE);
      done_r     <= (state_next_s == DONE);
      en_write_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (bus.start_i) begin
            shift_r    <= '0;
            byte_idx_r <= 2'd0;
            count_r    <= '0;
            wr_addr_r  <= '0;
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
          end
        end
        ASSEMBLE: begin
          if (bus.rx_done_i) begin
            shift_r    <= {shift_r[NB_DATA-NB_BYTE-1:0], bus.rx_data_i};
            byte_idx_r <= byte_idx_r + 2'd1;
          end
          if (tmo_expire_s) timeout_r <= 1'b1;
        end
        WRITE: begin
          en_write_r  <= 1'b1;
          inst_load_r <= shift_r;
          wr_addr_r   <= count_r[ADDRWIDTH-1:0];
          count_r     <= count_r + CW'(1);
          if (!is_halt_s && last_addr_s) overflow_r <= 1'b1;
          // A strobe landing in the write cycle already belongs to the next word
          if (bus.rx_done_i && (state_next_s == ASSEMBLE)) begin
            shift_r    <= {shift_r[NB_DATA-NB_BYTE-1:0], bus.rx_data_i};
            byte_idx_r <= 2'd1;
          end
        end
        default: begin
          en_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst_load_o  = inst_load_r;
  assign bus.wr_addr_o    = wr_addr_r;
  assign bus.en_write_o   = en_write_r;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;
  assign bus.overflow_o   = overflow_r;
  assign bus.timeout_o    = timeout_r;
  assign bus.inst_count_o = count_r;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a 4-word memory and a 50-cycle timeout.
module tb_inst_loader;

  localparam int NB_DATA   = 32;
  localparam int NB_BYTE   = 8;
  localparam int ADDRWIDTH = 7;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   overlap_cnt;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  inst_loader_if #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .ADDRWIDTH(ADDRWIDTH)) bus ();

  inst_loader #(
    .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .ADDRWIDTH(ADDRWIDTH),
    .MEM_DEPTH(4), .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYCLES(50)
  ) dut (
    .clock_i(clk),
    .reset_i(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.en_write_o) begin
      wr_addr_q.push_back(32'(bus.wr_addr_o));
      wr_data_q.push_back(bus.inst_load_o);
    end
    if (bus.busy_o && bus.done_o) overlap_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data_i = b;
    bus.rx_done_i = 1'b1;
    @(negedge clk);
    bus.rx_done_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 3; i >= 0; i--) begin
      send_byte(tmp[i*8 +: 8]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!bus.done_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_value(tag, 32'(bus.done_o), 32'd1);
  endtask

  task automatic clear_q();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  initial begin
    logic [31:0] words1 [3];
    int first_done;
    n_checks = 0;
    n_errors = 0;
    overlap_cnt = 0;
    words1[0] = 32'h2008_0005;
    words1[1] = 32'h2009_0007;
    words1[2] = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.rx_data_i = 8'h00;
    bus.rx_done_i = 1'b0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check_value("rst_busy", 32'(bus.busy_o), 32'd0);
    check_value("rst_done", 32'(bus.done_o), 32'd0);
    check_value("rst_en_write", 32'(bus.en_write_o), 32'd0);
    check_value("rst_inst_load", bus.inst_load_o, 32'd0);
    check_value("rst_count", 32'(bus.inst_count_o), 32'd0);
    check_value("rst_flags", {30'd0, bus.overflow_o, bus.timeout_o}, 32'd0);

    // three-word load; a strobe alongside start must be ignored
    clear_q();
    bus.rx_data_i = 8'hAA;
    bus.rx_done_i = 1'b1;
    pulse_start();
    bus.rx_done_i = 1'b0;
    check_value("t1_busy", 32'(bus.busy_o), 32'd1);
    for (int w = 0; w < 3; w++) send_word(words1[w], 1'b1);
    wait_done("t1_done", 20);
    idle(2);
    check_value("t1_nwrites", 32'(wr_data_q.size()), 32'd3);
    for (int w = 0; w < 3; w++) begin
      check_value($sformatf("t1_data%0d", w), wr_data_q[w], words1[w]);
      check_value($sformatf("t1_addr%0d", w), wr_addr_q[w], 32'(w));
    end
    check_value("t1_count", 32'(bus.inst_count_o), 32'd3);
    check_value("t1_overflow", 32'(bus.overflow_o), 32'd0);
    check_value("t1_busy_off", 32'(bus.busy_o), 32'd0);
    check_value("t1_hold_addr", 32'(bus.wr_addr_o), 32'd2);

    // overflow on a 4-word memory
    clear_q();
    pulse_start();
    for (int w = 0; w < 4; w++) send_word({8'h10 + 8'(w), 8'h20 + 8'(w), 8'h30 + 8'(w), 8'h40 + 8'(w)}, 1'b0);
    wait_done("t2_done", 20);
    idle(2);
    check_value("t2_nwrites", 32'(wr_data_q.size()), 32'd4);
    for (int w = 0; w < 4; w++) begin
      check_value($sformatf("t2_addr%0d", w), wr_addr_q[w], 32'(w));
      check_value($sformatf("t2_data%0d", w), wr_data_q[w], {8'h10 + 8'(w), 8'h20 + 8'(w), 8'h30 + 8'(w), 8'h40 + 8'(w)});
    end
    check_value("t2_overflow", 32'(bus.overflow_o), 32'd1);
    check_value("t2_count", 32'(bus.inst_count_o), 32'd4);
    check_value("t2_hold_addr", 32'(bus.wr_addr_o), 32'd3);
    send_word(32'h5566_7788, 1'b0);
    idle(3);
    check_value("t2_no_5th", 32'(wr_data_q.size()), 32'd4);

    // restart from DONE clears flags and address
    pulse_start();
    check_value("t2r_overflow", 32'(bus.overflow_o), 32'd0);
    check_value("t2r_count", 32'(bus.inst_count_o), 32'd0);
    check_value("t2r_state", {30'd0, bus.busy_o, bus.done_o}, 32'd2);
    check_value("t2r_addr", 32'(bus.wr_addr_o), 32'd0);

    // reset mid-word discards the partial bytes
    clear_q();
    send_byte(8'hDE);
    send_byte(8'hAD);
    #2 rst_n = 1'b0;
    #1;
    check_value("t3_async_busy", 32'(bus.busy_o), 32'd0);
    check_value("t3_async_count", 32'(bus.inst_count_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send_word(32'h1122_3344, 1'b1);
    idle(3);
    check_value("t3_nwrites", 32'(wr_data_q.size()), 32'd1);
    check_value("t3_data", wr_data_q[0], 32'h1122_3344);
    check_value("t3_addr", wr_addr_q[0], 32'd0);

    // back-to-back strobes, then restart
    do_reset();
    @(negedge clk);
    clear_q();
    pulse_start();
    send_word(32'h0123_4567, 1'b0);
    send_word(32'h89AB_CDEF, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    wait_done("t4_done", 20);
    idle(2);
    check_value("t4_nwrites", 32'(wr_data_q.size()), 32'd3);
    check_value("t4_data0", wr_data_q[0], 32'h0123_4567);
    check_value("t4_data1", wr_data_q[1], 32'h89AB_CDEF);
    check_value("t4_data2", wr_data_q[2], 32'hFFFF_FFFF);
    check_value("t4_addr2", wr_addr_q[2], 32'd2);
    send_word(32'h1357_9BDF, 1'b0);
    idle(2);
    check_value("t4_done_ignores_rx", 32'(wr_data_q.size()), 32'd3);
    clear_q();
    pulse_start();
    check_value("t4r_flags", {29'd0, bus.done_o, bus.overflow_o, bus.timeout_o}, 32'd0);
    send_word(32'hCAFE_F00D, 1'b0);
    idle(3);
    check_value("t4r_nwrites", 32'(wr_data_q.size()), 32'd1);
    check_value("t4r_data", wr_data_q[0], 32'hCAFE_F00D);
    check_value("t4r_addr", wr_addr_q[0], 32'd0);
    check_value("t4r_count", 32'(bus.inst_count_o), 32'd1);

    // inter-byte timeout
    do_reset();
    @(negedge clk);
    clear_q();
    pulse_start();
    send_byte(8'h42);
    first_done = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done_o && first_done == 0) first_done = k;
    end
`ifdef LOADER_TIMEOUT_EN
    check_value("t5_done_cycle", 32'(first_done), 32'd50);
    check_value("t5_timeout", 32'(bus.timeout_o), 32'd1);
    check_value("t5_done", 32'(bus.done_o), 32'd1);
`else
    check_value("t5_no_done", 32'(first_done), 32'd0);
    check_value("t5_timeout", 32'(bus.timeout_o), 32'd0);
    check_value("t5_busy", 32'(bus.busy_o), 32'd1);
`endif
    check_value("t5_no_write", 32'(wr_data_q.size()), 32'd0);

    check_value("busy_done_overlap", 32'(overlap_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
